// File: rtl/rv32e_data_mem_pkg.sv
// ----------------------------------------------------------------------------
// rv32e_data_mem_pkg: data-bus address map, status bit positions, UART FSM codes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rv32e_data_mem_pkg;

    localparam logic [31:0] RAM_BASE         = 32'h0000_0000;
    localparam logic [31:0] ADDR_GPIO_OUT    = 32'h0000_1000;
    localparam logic [31:0] ADDR_CYCLE       = 32'h0000_1004;
    localparam logic [31:0] ADDR_UART_DATA   = 32'h0000_1008;
    localparam logic [31:0] ADDR_UART_STATUS = 32'h0000_100C;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_W   = 4;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    // Registers are word-aligned; the byte offset inside a word is ignored.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32e_uart_tx.sv
// ----------------------------------------------------------------------------
// rv32e_uart_tx: byte FIFO feeding an 8N1 serial transmitter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rv32e_uart_tx
    import rv32e_data_mem_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 434,
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       push_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             tx,
    output logic             pop
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;

    logic w_baud_done;
    logic w_pop;
    logic w_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_baud_done = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign empty       = (r_count == '0);
    assign full        = (r_count == CNT_W'(FIFO_DEPTH));
    // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
    assign w_pop       = !empty && ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_baud_done));
    assign w_push      = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_fifo[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (w_pop) begin
                        r_state <= TX_START;
                        r_baud  <= '0;
                        r_shift <= r_fifo[r_rd_ptr];
                        r_tx    <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= TX_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= TX_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_state <= TX_START;
                            r_shift <= r_fifo[r_rd_ptr];
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= TX_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign count = r_count;
    assign busy  = (r_state != TX_IDLE);
    assign tx    = r_tx;
    assign pop   = w_pop;

endmodule

`default_nettype wire

// File: rtl/rv32e_data_mem.sv
// ----------------------------------------------------------------------------
// rv32e_data_mem: RV32E data bus with word RAM, GPIO, cycle counter and UART
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rv32e_data_mem
    import rv32e_data_mem_pkg::*;
#(
    parameter int RAM_WORDS    = 256,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr_bus,
    input  logic [31:0] mem_write_data_bus,
    input  logic        mem_write_signal,
    output logic [31:0] mem_read_data_bus,
    output logic [15:0] gpio_out,
    output logic        uart_tx
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [31:0] r_ram [RAM_WORDS];
    logic [15:0] r_gpio;
    logic [31:0] r_cycle;
    logic        r_overflow;

    logic [31:0]       w_addr;
    logic              w_we;
    logic              w_sel_ram;
    logic              w_sel_gpio;
    logic              w_sel_cycle;
    logic              w_sel_udata;
    logic              w_sel_ustat;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_uart_push;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_busy;
    logic              w_pop;
    logic [31:0]       w_status;

    assign w_addr      = word_addr(mem_addr_bus);
    // Stores are blocked entirely while reset is asserted.
    assign w_we        = mem_write_signal && reset;
    assign w_sel_ram   = (mem_addr_bus < RAM_BASE + 32'(RAM_WORDS * 4));
    assign w_sel_gpio  = (w_addr == ADDR_GPIO_OUT);
    assign w_sel_cycle = (w_addr == ADDR_CYCLE);
    assign w_sel_udata = (w_addr == ADDR_UART_DATA);
    assign w_sel_ustat = (w_addr == ADDR_UART_STATUS);
    assign w_ram_idx   = mem_addr_bus[RAM_AW+1:2];
    assign w_uart_push = w_we && w_sel_udata;

    always_ff @(posedge clk) begin
        if (w_we && w_sel_ram) begin
            r_ram[w_ram_idx] <= mem_write_data_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gpio     <= '0;
            r_cycle    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_we && w_sel_gpio) r_gpio <= mem_write_data_bus[15:0];
            if (w_we && w_sel_cycle) r_cycle <= mem_write_data_bus;
            else                     r_cycle <= r_cycle + 32'd1;
            // A byte dropped on the clearing edge keeps the flag set.
            if (w_uart_push && w_full && !w_pop) r_overflow <= 1'b1;
            else if (w_we && w_sel_ustat)        r_overflow <= 1'b0;
        end
    end

    rv32e_uart_tx #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk       (clk),
        .reset     (reset),
        .push      (w_uart_push),
        .push_data (mem_write_data_bus[7:0]),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty),
        .busy      (w_busy),
        .tx        (uart_tx),
        .pop       (w_pop)
    );

    always_comb begin
        w_status                                   = '0;
        w_status[STAT_FULL]                        = w_full;
        w_status[STAT_EMPTY]                       = w_empty;
        w_status[STAT_BUSY]                        = w_busy;
        w_status[STAT_OVERFLOW]                    = r_overflow;
        w_status[STAT_COUNT_LSB +: STAT_COUNT_W]   = STAT_COUNT_W'(w_count);
    end

    always_comb begin
        mem_read_data_bus = '0;
        if (w_sel_ram)        mem_read_data_bus = r_ram[w_ram_idx];
        else if (w_sel_gpio)  mem_read_data_bus = {16'h0000, r_gpio};
        else if (w_sel_cycle) mem_read_data_bus = r_cycle;
        else if (w_sel_ustat) mem_read_data_bus = w_status;
    end

    assign gpio_out = r_gpio;

endmodule

`default_nettype wire

// File: tb/tb_rv32e_data_mem.sv
// ----------------------------------------------------------------------------
// tb_rv32e_data_mem: directed self-checking bench for rv32e_data_mem
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rv32e_data_mem;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        we    = 1'b0;
    logic [31:0] rdata;
    logic [15:0] gpio;
    logic        tx;

    int tests = 0;
    int fails = 0;

    // start bit, 0xA5 LSB first, stop bit (index 0 is sent first)
    logic [9:0] frame_a5 = 10'b1_1010_0101_0;
    logic       saw_low;

    always #5 clk = ~clk;

    rv32e_data_mem #(
        .RAM_WORDS    (256),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_addr_bus       (addr),
        .mem_write_data_bus (wdata),
        .mem_write_signal   (we),
        .mem_read_data_bus  (rdata),
        .gpio_out           (gpio),
        .uart_tx            (tx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        // Reset, with a store attempted while reset is low
        reset = 1'b0;
        addr  = 32'h1000;
        wdata = 32'h0000_FFFF;
        we    = 1'b1;
        tick();
        tick();
        we = 1'b0;
        check("rst_gpio", {16'h0, gpio}, 32'h0);
        check("rst_tx", {31'h0, tx}, 32'h1);
        rd("rst_cycle", 32'h1004, 32'h0);
        rd("rst_status", 32'h100C, 32'h02);
        reset = 1'b1;
        addr  = 32'h1004;
        tick();
        rd("cycle_first", 32'h1004, 32'h1);

        // RAM
        wr(32'h14, 32'h1122_3344);
        wr(32'h10, 32'hDEAD_BEEF);
        rd("ram_10", 32'h10, 32'hDEAD_BEEF);
        rd("ram_13", 32'h13, 32'hDEAD_BEEF);
        rd("ram_14", 32'h14, 32'h1122_3344);

        // GPIO
        wr(32'h1000, 32'hABCD_1234);
        check("gpio_out", {16'h0, gpio}, 32'h0000_1234);
        rd("gpio_rd", 32'h1002, 32'h0000_1234);

        // Unmapped access and write-only data register
        wr(32'h2000, 32'h1234_5678);
        rd("unmapped", 32'h2000, 32'h0);
        check("unmapped_gpio", {16'h0, gpio}, 32'h0000_1234);
        rd("unmapped_ram", 32'h10, 32'hDEAD_BEEF);
        rd("udata_rd", 32'h1008, 32'h0);

        // CYCLE load and wrap
        wr(32'h1004, 32'hFFFF_FFFE);
        rd("cycle_n1", 32'h1004, 32'hFFFF_FFFE);
        tick();
        rd("cycle_n2", 32'h1004, 32'hFFFF_FFFF);
        tick();
        rd("cycle_n3", 32'h1004, 32'h0000_0000);

        // Single UART frame of 0xA5, checked every cycle
        wr(32'h1008, 32'h0000_00A5);
        tick();
        for (int i = 0; i < 40; i++) begin
            check("uart_bit", {31'h0, tx}, {31'h0, frame_a5[i/4]});
            if (i == 1) rd("status_busy", 32'h100C, 32'h06);
            tick();
        end
        check("uart_idle_tx", {31'h0, tx}, 32'h1);
        rd("status_done", 32'h100C, 32'h02);

        // Overflow: five pushes while a frame of 0x55 is in START
        wr(32'h1008, 32'h0000_0055);
        tick();
        addr = 32'h1008;
        we   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wdata = 32'(k + 1);
            tick();
        end
        we = 1'b0;
        rd("status_ovf", 32'h100C, 32'h4D);
        wr(32'h100C, 32'h0);
        rd("status_ovf_clr", 32'h100C, 32'h45);

        // Mid-frame reset while sending data bit 1 of 0x55 (a 0)
        tick();
        tick();
        tick();
        check("tx_data_bit1", {31'h0, tx}, 32'h0);
        reset = 1'b0;
        tick();
        check("midrst_tx", {31'h0, tx}, 32'h1);
        check("midrst_gpio", {16'h0, gpio}, 32'h0);
        reset = 1'b1;
        rd("midrst_status", 32'h100C, 32'h02);
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1) saw_low = 1'b1;
            tick();
        end
        check("midrst_no_bits", {31'h0, saw_low}, 32'h0);
        rd("midrst_status2", 32'h100C, 32'h02);
        rd("midrst_ram", 32'h10, 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv32e_data_mem.md
RV32E_DATA_MEM -- requirements
Module: rv32e_data_mem

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, data RAM depth in 32-bit words (power of two, at most 1024).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, UART transmit FIFO depth in bytes (power of two).
REQ-003 SHALL have parameter CLKS_PER_BIT, default 434, UART bit period in clk cycles (at least 2).
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port mem_addr_bus, input, 32 bits: CPU byte address; addr[1:0] is ignored.
REQ-007 SHALL have port mem_write_data_bus, input, 32 bits: CPU store data.
REQ-008 SHALL have port mem_write_signal, input, 1 bit: store strobe; one write per rising edge while it is high.
REQ-009 SHALL have port mem_read_data_bus, output, 32 bits: load data, combinational from mem_addr_bus.
REQ-010 SHALL have port gpio_out, output, 16 bits: GPIO output register.
REQ-011 SHALL have port uart_tx, output, 1 bit: UART serial line, idle high.

Function
REQ-012 SHALL decode addresses as follows:
- addr < RAM_WORDS*4: RAM, word index addr[log2(RAM_WORDS)+1:2].
- 0x1000: GPIO_OUT, read/write; bits [15:0] used, upper bits read as 0.
- 0x1004: CYCLE, read/write.
- 0x1008: UART_DATA; a write pushes byte [7:0]; a read returns 0.
- 0x100C: UART_STATUS; bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow (sticky), bits[7:4] FIFO count; all other bits 0.
REQ-013 SHALL return 0 for reads of unmapped addresses and SHALL ignore writes to them.
REQ-014 SHALL provide read data in the same cycle as the address (zero latency); a value written at edge N SHALL be readable from cycle N+1.
REQ-015 SHALL increment CYCLE by 1 every clock, wrapping from 0xFFFFFFFF to 0; a write loads the written value, takes priority over the increment, and counting resumes on the next edge.
REQ-016 SHALL push a byte to the FIFO on a UART_DATA write when count < FIFO_DEPTH, or when a pop occurs on the same edge; otherwise it SHALL drop the byte and set overflow.
REQ-017 SHALL clear overflow on any write to UART_STATUS; a new overflow on that same edge SHALL win.
REQ-018 SHALL leave count unchanged on a simultaneous push and pop.
REQ-019 SHALL run the transmitter FSM IDLE->START->DATA->STOP->(IDLE, or START if the FIFO is non-empty), with each state lasting CLKS_PER_BIT cycles per bit.
REQ-020 SHALL pop the FIFO on the edge the FSM leaves IDLE or STOP toward START; uart_tx SHALL be low from the following cycle.
REQ-021 SHALL send the frame as start bit 0, then 8 data bits LSB first, then stop bit 1: 10 bit periods, back-to-back frames with no idle gap.
REQ-022 SHALL assert tx_busy exactly when the FSM state is not IDLE.
REQ-023 SHALL drive uart_tx = 1 in IDLE and STOP.

Reset
REQ-024 SHALL, while reset=0 at a rising edge, set gpio_out=0, CYCLE=0, FIFO empty (count 0), overflow=0, FSM=IDLE, uart_tx=1, and the bit and baud counters to 0.
REQ-025 SHALL abort an in-flight frame on reset: uart_tx goes high at the reset edge and pending bytes are discarded.
REQ-026 SHALL leave RAM contents unaffected by reset; the simulation initial value is X.
REQ-027 SHALL ignore mem_write_signal while reset=0.

Structure
REQ-028 SHALL place the address map constants (RAM base, GPIO/CYCLE/UART_DATA/UART_STATUS addresses) and the status bit positions in a shared include/package used by the CPU testbenches and firmware.
REQ-029 SHALL implement the FIFO and transmitter FSM in one sub-module, rv32e_uart_tx, with ports: push, push_data[7:0], count, full, empty, busy, tx.
REQ-030 SHALL contain no other sub-modules; RAM is an inferred register array.

Verification
REQ-031 SHALL cover RAM: write 0xDEADBEEF to 0x0010, then read 0x0010 and 0x0013 -> both return 0xDEADBEEF; read 0x0014 -> unrelated word unchanged.
REQ-032 SHALL cover CYCLE: write 0xFFFFFFFE at edge N -> read 0xFFFFFFFE in cycle N+1, 0xFFFFFFFF in N+2, 0x00000000 in N+3.
REQ-033 SHALL cover UART frame: with CLKS_PER_BIT=4, write 0xA5 to 0x1008 -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1 (4 cycles each); STATUS bit2 clears after the stop bit.
REQ-034 SHALL cover overflow: five UART_DATA writes on consecutive edges while busy, with FIFO_DEPTH=4 -> STATUS = full|overflow|count 4; a write to 0x100C clears bit3.
REQ-035 SHALL cover mid-frame reset: reset=0 for 1 cycle during the DATA state -> uart_tx=1, STATUS=0x02, gpio_out=0, and no further frame bits are sent.
REQ-036 SHALL cover unmapped access: write 0x12345678 to 0x2000, then read it -> 0; GPIO and RAM are unchanged.
